// File: rtl/lsu_pkg.sv
// lsu_pkg
// Shared definitions for the load/store unit: the opcode values taken from the
// low four bits of the MIPS load/store opcodes, the FSM state type, the access
// size encoding carried in op[1:0], and small helpers that decode legality and
// alignment of a request.
package lsu_pkg;

  // Opcodes (low nibble of the MIPS opcode)
  localparam logic [3:0] OP_LB  = 4'b0000;
  localparam logic [3:0] OP_LH  = 4'b0001;
  localparam logic [3:0] OP_LW  = 4'b0011;
  localparam logic [3:0] OP_LBU = 4'b0100;
  localparam logic [3:0] OP_LHU = 4'b0101;
  localparam logic [3:0] OP_SB  = 4'b1000;
  localparam logic [3:0] OP_SH  = 4'b1001;
  localparam logic [3:0] OP_SW  = 4'b1011;

  // Access size lives in op[1:0]; op[2] marks an unsigned load, op[3] a store
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_RMW_READ = 3'd2,
    ST_WRITE    = 3'd3,
    ST_RESP     = 3'd4
  } lsu_state_t;

  // Only the eight load/store codes are accepted; everything else is an error
  function automatic logic op_is_legal(input logic [3:0] op);
    case (op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
      OP_SB, OP_SH, OP_SW: return 1'b1;
      default:             return 1'b0;
    endcase
  endfunction

  // Halfwords need an even address, words a multiple of four
  function automatic logic addr_aligned(input logic [1:0] size, input logic [1:0] low);
    case (size)
      SIZE_HALF: return ~low[0];
      SIZE_WORD: return (low == 2'b00);
      default:   return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lane_align.sv
// lane_align
// Purely combinational byte-lane steering for the load/store unit.
// Load path: picks the byte or halfword lane out of a memory word and sign- or
// zero-extends it (words pass through). Store path: replaces only the target
// lane of an old memory word with the right-justified store data.
// Ports:
//   i_size        access size (SIZE_BYTE / SIZE_HALF / SIZE_WORD)
//   i_unsigned    zero-extend loads when set
//   i_byte_sel    byte address bits [1:0]
//   i_load_word   memory word to extract from
//   i_old_word    memory word to merge into
//   i_store_data  right-justified store data
//   o_load_result extended load result
//   o_merged_word old word with the target lane replaced
module lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [1:0]  i_byte_sel,
  input  logic [31:0] i_load_word,
  input  logic [31:0] i_old_word,
  input  logic [31:0] i_store_data,
  output logic [31:0] o_load_result,
  output logic [31:0] o_merged_word
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Little-endian lane select followed by extension
  always_comb begin
    w_byte = 8'h00;
    case (i_byte_sel)
      2'd0: w_byte = i_load_word[7:0];
      2'd1: w_byte = i_load_word[15:8];
      2'd2: w_byte = i_load_word[23:16];
      2'd3: w_byte = i_load_word[31:24];
      default: w_byte = 8'h00;
    endcase
    w_half = i_byte_sel[1] ? i_load_word[31:16] : i_load_word[15:0];

    o_load_result = i_load_word;
    case (i_size)
      SIZE_BYTE: o_load_result = i_unsigned ? {24'h000000, w_byte}
                                            : {{24{w_byte[7]}}, w_byte};
      SIZE_HALF: o_load_result = i_unsigned ? {16'h0000, w_half}
                                            : {{16{w_half[15]}}, w_half};
      default:   o_load_result = i_load_word;
    endcase
  end

  // Read-modify-write merge: untouched lanes keep the old memory contents
  always_comb begin
    o_merged_word = i_old_word;
    case (i_size)
      SIZE_BYTE: begin
        case (i_byte_sel)
          2'd0: o_merged_word[7:0]   = i_store_data[7:0];
          2'd1: o_merged_word[15:8]  = i_store_data[7:0];
          2'd2: o_merged_word[23:16] = i_store_data[7:0];
          2'd3: o_merged_word[31:24] = i_store_data[7:0];
          default: o_merged_word = i_old_word;
        endcase
      end
      SIZE_HALF: begin
        if (i_byte_sel[1]) o_merged_word[31:16] = i_store_data[15:0];
        else               o_merged_word[15:0]  = i_store_data[15:0];
      end
      default: o_merged_word = i_store_data;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit
// Initiator-side memory access unit for the single-cycle MIPS datapath. Takes
// one load/store request at a time and drives a word-only data memory port.
// Sub-word loads are extracted and extended; sub-word stores are done as a
// read-modify-write. Illegal, misaligned and out-of-range requests return an
// error response without touching memory.
// Ports:
//   i_clk, i_reset            clock, synchronous active-high reset
//   i_req_valid/o_req_ready   request handshake (accept when both high)
//   i_req_op/addr/wdata       opcode nibble, byte address, store data
//   o_resp_valid              one-cycle response pulse
//   o_resp_rdata/o_resp_err   extended load data / error flag (held)
//   o_mem_addr/o_mem_wdata    word-aligned address / merged write word
//   o_mem_write/o_mem_read    memory strobes
//   i_mem_rdata               combinational read data
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 1024
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [3:0]  i_req_op,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_resp_valid,
  output logic [31:0] o_resp_rdata,
  output logic        o_resp_err,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic        o_mem_write,
  output logic        o_mem_read,
  input  logic [31:0] i_mem_rdata
);

  // Compared with a 33-bit limit so a full 4 GiB memory would still work
  localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) * 33'd4;

  lsu_state_t  r_state;
  logic        r_req_ready;
  logic        r_resp_valid;
  logic [31:0] r_resp_rdata;
  logic        r_resp_err;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic        r_mem_write;
  logic        r_mem_read;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [1:0]  r_byte_sel;
  logic [31:0] r_wdata;

  logic        w_req_err;
  logic [31:0] w_load_result;
  logic [31:0] w_merged_word;

  // Request screening happens on the raw inputs so the error path can go
  // straight to the response state on the accept edge
  assign w_req_err = ~op_is_legal(i_req_op)
                   | ~addr_aligned(i_req_op[1:0], i_req_addr[1:0])
                   | ({1'b0, i_req_addr} >= ADDR_LIMIT);

  // Both the load path and the RMW merge work on the live memory read data
  lane_align u_lane_align (
    .i_size        (r_size),
    .i_unsigned    (r_unsigned),
    .i_byte_sel    (r_byte_sel),
    .i_load_word   (i_mem_rdata),
    .i_old_word    (i_mem_rdata),
    .i_store_data  (r_wdata),
    .o_load_result (w_load_result),
    .o_merged_word (w_merged_word)
  );

  // Single FSM process; every output is registered and updated on the edge
  // that enters the state in which it must be seen
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'h0;
      r_resp_err   <= 1'b0;
      r_mem_addr   <= 32'h0;
      r_mem_wdata  <= 32'h0;
      r_mem_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_size       <= SIZE_BYTE;
      r_unsigned   <= 1'b0;
      r_byte_sel   <= 2'b00;
      r_wdata      <= 32'h0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_req_valid) begin
            r_req_ready <= 1'b0;
            r_size      <= i_req_op[1:0];
            r_unsigned  <= i_req_op[2];
            r_byte_sel  <= i_req_addr[1:0];
            r_wdata     <= i_req_wdata;
            if (w_req_err) begin
              r_state      <= ST_RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_rdata <= 32'h0;
            end else begin
              r_mem_addr <= {i_req_addr[31:2], 2'b00};
              if (!i_req_op[3]) begin
                r_state    <= ST_LOAD;
                r_mem_read <= 1'b1;
              end else if (i_req_op[1:0] == SIZE_WORD) begin
                r_state     <= ST_WRITE;
                r_mem_write <= 1'b1;
                r_mem_wdata <= i_req_wdata;
              end else begin
                r_state    <= ST_RMW_READ;
                r_mem_read <= 1'b1;
              end
            end
          end
        end
        ST_LOAD: begin
          r_mem_read   <= 1'b0;
          r_resp_rdata <= w_load_result;
          r_resp_err   <= 1'b0;
          r_resp_valid <= 1'b1;
          r_state      <= ST_RESP;
        end
        ST_RMW_READ: begin
          r_mem_read  <= 1'b0;
          r_mem_write <= 1'b1;
          r_mem_wdata <= w_merged_word;
          r_state     <= ST_WRITE;
        end
        ST_WRITE: begin
          r_mem_write  <= 1'b0;
          r_resp_rdata <= 32'h0;
          r_resp_err   <= 1'b0;
          r_resp_valid <= 1'b1;
          r_state      <= ST_RESP;
        end
        ST_RESP: begin
          r_resp_valid <= 1'b0;
          r_req_ready  <= 1'b1;
          r_state      <= ST_IDLE;
        end
        default: begin
          r_state      <= ST_IDLE;
          r_req_ready  <= 1'b1;
          r_resp_valid <= 1'b0;
          r_mem_read   <= 1'b0;
          r_mem_write  <= 1'b0;
        end
      endcase
    end
  end

  assign o_req_ready  = r_req_ready;
  assign o_resp_valid = r_resp_valid;
  assign o_resp_rdata = r_resp_rdata;
  assign o_resp_err   = r_resp_err;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_wdata  = r_mem_wdata;
  assign o_mem_read   = r_mem_read;
  // A reset edge during WRITE must not commit the half-finished store
  assign o_mem_write  = r_mem_write & ~i_reset;

endmodule
